// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg
//   Shared definitions for the pipelined bitwise logic unit:
//   - op_t and the OP_AND..OP_PASS encodings
//   - legal STAGES range (MIN_STAGES..MAX_STAGES)
//   - parity helper used by the optional flag logic (LOGIC_UNIT_FLAGS_EN)
package logic_unit_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_AND  = 3'b000;
  localparam op_t OP_OR   = 3'b001;
  localparam op_t OP_XOR  = 3'b010;
  localparam op_t OP_NAND = 3'b011;
  localparam op_t OP_NOR  = 3'b100;
  localparam op_t OP_XNOR = 3'b101;
  localparam op_t OP_ANDN = 3'b110;
  localparam op_t OP_PASS = 3'b111;

  localparam int MIN_STAGES = 1;
  localparam int MAX_STAGES = 4;

  // Even parity of a value zero-extended to 64 bits (WIDTH never exceeds 64).
  function automatic logic parity64(input logic [63:0] value);
    return ^value;
  endfunction

endpackage

// File: rtl/logic_unit_core.sv
// logic_unit_core
//   Purely combinational evaluation of one of eight bitwise ops.
//   Optional macro LOGIC_UNIT_FLAGS_EN adds zero and parity flags of the result.
// Ports:
//   op      in   3      operation select (see logic_unit_pkg)
//   a, b    in   WIDTH  operands
//   result  out  WIDTH  op(a, b)
//   zero    out  1      result == 0          (LOGIC_UNIT_FLAGS_EN only)
//   parity  out  1      XOR-reduce of result (LOGIC_UNIT_FLAGS_EN only)
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef LOGIC_UNIT_FLAGS_EN
  output logic             zero,
  output logic             parity,
`endif
  output logic [WIDTH-1:0] result
);

  // Bitwise operation select.
  always_comb begin
    result = {WIDTH{1'b0}};
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_XNOR: result = ~(a ^ b);
      OP_ANDN: result = a & ~b;
      OP_PASS: result = a;
      default: result = {WIDTH{1'b0}};
    endcase
  end

`ifdef LOGIC_UNIT_FLAGS_EN
  logic [63:0] result_ext;

  // Flags derived from the result, widened so the 64-bit parity helper fits any WIDTH.
  always_comb begin
    result_ext               = 64'd0;
    result_ext[WIDTH-1:0]    = result;
    zero                     = (result == {WIDTH{1'b0}});
    parity                   = parity64(result_ext);
  end
`endif

endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe
//   Pipelined bitwise logic unit: logic_unit_core result carried through
//   STAGES register stages under a valid/ready handshake. Latency = STAGES.
//   A single global enable (adv) moves the whole pipe; bubbles are carried.
//   Optional macro LOGIC_UNIT_FLAGS_EN adds out_zero / out_parity outputs.
// Parameters: WIDTH (1..64), STAGES (MIN_STAGES..MAX_STAGES).
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     input handshake; in_op, in1, in2 operand beat
//   out_valid/out_ready   output handshake; Out result, out_op producing op
//   out_zero, out_parity  result flags (LOGIC_UNIT_FLAGS_EN only)
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
`ifdef LOGIC_UNIT_FLAGS_EN
  output logic             out_zero,
  output logic             out_parity,
`endif
  output logic [2:0]       out_op
);

  logic             adv;
  logic [WIDTH-1:0] result;

  logic [STAGES-1:0] valid_q, valid_d;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];
  op_t               op_q   [STAGES];
  op_t               op_d   [STAGES];

`ifdef LOGIC_UNIT_FLAGS_EN
  logic              zero_s, parity_s;
  logic [STAGES-1:0] zero_q, zero_d, parity_q, parity_d;
`endif

  logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .op     (in_op),
    .a      (in1),
    .b      (in2),
`ifdef LOGIC_UNIT_FLAGS_EN
    .zero   (zero_s),
    .parity (parity_s),
`endif
    .result (result)
  );

  // An empty last stage frees the whole pipe even when the consumer stalls.
  assign adv      = out_ready | ~valid_q[STAGES-1];
  assign in_ready = adv & ~reset;

  // Next-state: shift every stage by one when enabled, otherwise hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    op_d    = op_q;
`ifdef LOGIC_UNIT_FLAGS_EN
    zero_d   = zero_q;
    parity_d = parity_q;
`endif
    if (adv) begin
      valid_d[0] = in_valid & in_ready;
      data_d[0]  = result;
      op_d[0]    = in_op;
`ifdef LOGIC_UNIT_FLAGS_EN
      zero_d[0]   = zero_s;
      parity_d[0] = parity_s;
`endif
      for (int s = 1; s < STAGES; s++) begin
        valid_d[s] = valid_q[s-1];
        data_d[s]  = data_q[s-1];
        op_d[s]    = op_q[s-1];
`ifdef LOGIC_UNIT_FLAGS_EN
        zero_d[s]   = zero_q[s-1];
        parity_d[s] = parity_q[s-1];
`endif
      end
    end else begin
      valid_d = valid_q;
      data_d  = data_q;
      op_d    = op_q;
`ifdef LOGIC_UNIT_FLAGS_EN
      zero_d   = zero_q;
      parity_d = parity_q;
`endif
    end
  end

  // Stage registers; reset discards every in-flight beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= {STAGES{1'b0}};
      for (int s = 0; s < STAGES; s++) begin
        data_q[s] <= {WIDTH{1'b0}};
        op_q[s]   <= 3'b000;
      end
`ifdef LOGIC_UNIT_FLAGS_EN
      zero_q   <= {STAGES{1'b0}};
      parity_q <= {STAGES{1'b0}};
`endif
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      op_q    <= op_d;
`ifdef LOGIC_UNIT_FLAGS_EN
      zero_q   <= zero_d;
      parity_q <= parity_d;
`endif
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign Out       = data_q[STAGES-1];
  assign out_op    = op_q[STAGES-1];
`ifdef LOGIC_UNIT_FLAGS_EN
  assign out_zero   = zero_q[STAGES-1];
  assign out_parity = parity_q[STAGES-1];
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe
//   Directed, table-driven bench for logic_unit_pipe: main instance WIDTH=32/STAGES=2
//   plus corner instances WIDTH=1/STAGES=1 and WIDTH=64/STAGES=4.
//   Flag outputs are checked when LOGIC_UNIT_FLAGS_EN is defined.
module tb_logic_unit_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // main instance
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  in_op, out_op;
  logic [31:0] in1, in2, dout;
`ifdef LOGIC_UNIT_FLAGS_EN
  logic out_zero, out_parity, c1_zero, c1_par, c64_zero, c64_par;
`endif

  logic_unit_pipe #(.WIDTH(32), .STAGES(2)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in1(in1), .in2(in2), .out_valid(out_valid),
    .out_ready(out_ready), .Out(dout),
`ifdef LOGIC_UNIT_FLAGS_EN
    .out_zero(out_zero), .out_parity(out_parity),
`endif
    .out_op(out_op)
  );

  // corner instances
  logic       c1_in_valid, c1_in_ready, c1_out_valid;
  logic [2:0] c1_in_op, c1_out_op;
  logic [0:0] c1_in1, c1_in2, c1_out;
  logic        c64_in_valid, c64_in_ready, c64_out_valid;
  logic [2:0]  c64_in_op, c64_out_op;
  logic [63:0] c64_in1, c64_in2, c64_out;

  logic_unit_pipe #(.WIDTH(1), .STAGES(1)) u_c1 (
    .clk(clk), .reset(reset), .in_valid(c1_in_valid), .in_ready(c1_in_ready),
    .in_op(c1_in_op), .in1(c1_in1), .in2(c1_in2), .out_valid(c1_out_valid),
    .out_ready(1'b1), .Out(c1_out),
`ifdef LOGIC_UNIT_FLAGS_EN
    .out_zero(c1_zero), .out_parity(c1_par),
`endif
    .out_op(c1_out_op)
  );

  logic_unit_pipe #(.WIDTH(64), .STAGES(4)) u_c64 (
    .clk(clk), .reset(reset), .in_valid(c64_in_valid), .in_ready(c64_in_ready),
    .in_op(c64_in_op), .in1(c64_in1), .in2(c64_in2), .out_valid(c64_out_valid),
    .out_ready(1'b1), .Out(c64_out),
`ifdef LOGIC_UNIT_FLAGS_EN
    .out_zero(c64_zero), .out_parity(c64_par),
`endif
    .out_op(c64_out_op)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        exp_zero;
    logic        exp_par;
  } vec_t;

  vec_t vecs[13];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } bp_t;

  bp_t bp[6];

  initial begin
    // op sweep on 0xDC / 0xEED
    vecs[0]  = '{3'b000, 32'h0000_00DC, 32'h0000_0EED, 32'h0000_00CC, 1'b0, 1'b0};
    vecs[1]  = '{3'b001, 32'h0000_00DC, 32'h0000_0EED, 32'h0000_0EFD, 1'b0, 1'b0};
    vecs[2]  = '{3'b010, 32'h0000_00DC, 32'h0000_0EED, 32'h0000_0E31, 1'b0, 1'b0};
    vecs[3]  = '{3'b011, 32'h0000_00DC, 32'h0000_0EED, 32'hFFFF_FF33, 1'b0, 1'b0};
    vecs[4]  = '{3'b100, 32'h0000_00DC, 32'h0000_0EED, 32'hFFFF_F102, 1'b0, 1'b0};
    vecs[5]  = '{3'b101, 32'h0000_00DC, 32'h0000_0EED, 32'hFFFF_F1CE, 1'b0, 1'b0};
    vecs[6]  = '{3'b110, 32'h0000_00DC, 32'h0000_0EED, 32'h0000_0010, 1'b0, 1'b0};
    vecs[7]  = '{3'b111, 32'h0000_00DC, 32'h0000_0EED, 32'h0000_00DC, 1'b0, 1'b0};
    // AND pair
    vecs[8]  = '{3'b000, 32'd11,        32'd1,         32'h0000_0001, 1'b0, 1'b1};
    vecs[9]  = '{3'b000, 32'hFFFF_FFFF, 32'd123456789, 32'h075B_CD15, 1'b0, 1'b0};
    // flag vectors
    vecs[10] = '{3'b000, 32'd6,         32'd9,         32'h0000_0000, 1'b1, 1'b0};
    vecs[11] = '{3'b001, 32'd6,         32'd9,         32'h0000_000F, 1'b0, 1'b0};
    vecs[12] = '{3'b111, 32'h7,         32'h0,         32'h0000_0007, 1'b0, 1'b1};

    bp[0] = '{32'd0,    32'd2,      32'd0};
    bp[1] = '{32'd101,  32'd1001,   32'd97};
    bp[2] = '{32'd6,    32'd9,      32'd0};
    bp[3] = '{32'd23,   32'd23,     32'd23};
    bp[4] = '{32'd255,  32'd15,     32'd15};
    bp[5] = '{32'h1234, 32'hFF00,   32'h1200};

    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; in_op = 3'b000; in1 = 32'd0; in2 = 32'd0;
    c1_in_valid = 1'b0; c1_in_op = 3'b000; c1_in1 = 1'b0; c1_in2 = 1'b0;
    c64_in_valid = 1'b0; c64_in_op = 3'b000; c64_in1 = 64'd0; c64_in2 = 64'd0;

    // ---------------- reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out", {32'd0, dout}, 64'd0);
    check("rst_out_op", {61'd0, out_op}, 64'd0);
    reset = 1'b0;
    #1;
    check("idle_in_ready", {63'd0, in_ready}, 64'd1);

    // ---------------- table: one beat at a time, latency 2
    for (int i = 0; i < 13; i++) begin
      in_valid = 1'b1; in_op = vecs[i].op; in1 = vecs[i].a; in2 = vecs[i].b;
      @(posedge clk); #1;             // accepted at this edge
      in_valid = 1'b0;
      check($sformatf("v%0d_early_valid", i), {63'd0, out_valid}, 64'd0);
      @(posedge clk); #1;
      check($sformatf("v%0d_valid", i), {63'd0, out_valid}, 64'd1);
      check($sformatf("v%0d_out", i), {32'd0, dout}, {32'd0, vecs[i].exp});
      check($sformatf("v%0d_op", i), {61'd0, out_op}, {61'd0, vecs[i].op});
`ifdef LOGIC_UNIT_FLAGS_EN
      check($sformatf("v%0d_zero", i), {63'd0, out_zero}, {63'd0, vecs[i].exp == 32'd0});
      check($sformatf("v%0d_par", i), {63'd0, out_parity}, {63'd0, ^vecs[i].exp});
      if (i >= 10) begin
        check($sformatf("v%0d_zero_tab", i), {63'd0, out_zero}, {63'd0, vecs[i].exp_zero});
        check($sformatf("v%0d_par_tab", i), {63'd0, out_parity}, {63'd0, vecs[i].exp_par});
      end
`endif
    end
    @(posedge clk); #1;

    // ---------------- back-to-back: results on consecutive cycles
    in_valid = 1'b1; in_op = 3'b000; in1 = 32'd11; in2 = 32'd1;
    @(posedge clk); #1;
    in1 = 32'hFFFF_FFFF; in2 = 32'd123456789;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_valid0", {63'd0, out_valid}, 64'd1);
    check("b2b_out0", {32'd0, dout}, 64'h1);
    @(posedge clk); #1;
    check("b2b_valid1", {63'd0, out_valid}, 64'd1);
    check("b2b_out1", {32'd0, dout}, 64'h075B_CD15);
    @(posedge clk); #1;
    check("b2b_drain", {63'd0, out_valid}, 64'd0);

    // ---------------- back-pressure: 4-cycle stall mid-stream
    begin
      int sent = 0;
      int recv = 0;
      logic        prev_stall = 1'b0;
      logic [31:0] prev_out = 32'd0;
      logic [2:0]  prev_op = 3'b000;
      logic fire_in, fire_out;
      for (int cyc = 0; cyc < 30; cyc++) begin
        out_ready = !(cyc >= 3 && cyc <= 6);
        in_valid  = (sent < 6);
        in_op     = 3'b000;
        in1       = (sent < 6) ? bp[sent].a : 32'd0;
        in2       = (sent < 6) ? bp[sent].b : 32'd0;
        #1;
        if (prev_stall) begin
          check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
          check("bp_hold_out", {32'd0, dout}, {32'd0, prev_out});
          check("bp_hold_op", {61'd0, out_op}, {61'd0, prev_op});
        end
        if (out_valid && !out_ready)
          check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        fire_in  = in_valid && in_ready;
        fire_out = out_valid && out_ready;
        if (fire_out) begin
          if (recv < 6) check($sformatf("bp_out%0d", recv), {32'd0, dout}, {32'd0, bp[recv].exp});
          else check("bp_extra_beat", 64'd1, 64'd0);
          recv++;
        end
        prev_stall = out_valid && !out_ready;
        prev_out   = dout;
        prev_op    = out_op;
        @(posedge clk); #1;
        if (fire_in) sent++;
      end
      check("bp_sent", sent, 64'd6);
      check("bp_recv", recv, 64'd6);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;

    // ---------------- reset with 2 beats in flight
    in_valid = 1'b1; in_op = 3'b001; in1 = 32'hA5A5_0000; in2 = 32'h0000_5A5A;
    @(posedge clk); #1;
    in1 = 32'h1111_1111;
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_out", {32'd0, dout}, 64'd0);
    check("mid_rst_op", {61'd0, out_op}, 64'd0);
    begin
      int ghosts = 0;
      for (int k = 0; k < 5; k++) begin
        @(posedge clk); #1;
        if (out_valid) ghosts++;
      end
      check("mid_rst_no_ghost", ghosts, 64'd0);
    end

    // ---------------- parameter corners: XOR all-ones with zero
    c1_in_valid = 1'b1; c1_in_op = 3'b010; c1_in1 = 1'b1; c1_in2 = 1'b0;
    c64_in_valid = 1'b1; c64_in_op = 3'b010; c64_in1 = {64{1'b1}}; c64_in2 = 64'd0;
    #1;
    check("c1_ready", {63'd0, c1_in_ready}, 64'd1);
    check("c64_ready", {63'd0, c64_in_ready}, 64'd1);
    @(posedge clk); #1;
    c1_in_valid = 1'b0; c64_in_valid = 1'b0;
    check("c1_valid", {63'd0, c1_out_valid}, 64'd1);
    check("c1_out", {63'd0, c1_out}, 64'd1);
    check("c1_op", {61'd0, c1_out_op}, 64'd2);
    for (int k = 1; k < 4; k++) begin
      check($sformatf("c64_early%0d", k), {63'd0, c64_out_valid}, 64'd0);
      @(posedge clk); #1;
    end
    check("c64_valid", {63'd0, c64_out_valid}, 64'd1);
    check("c64_out", c64_out, {64{1'b1}});
`ifdef LOGIC_UNIT_FLAGS_EN
    check("c64_zero", {63'd0, c64_zero}, 64'd0);
    check("c64_par", {63'd0, c64_par}, 64'd0);
`endif
    @(posedge clk); #1;
    check("c1_drain", {63'd0, c1_out_valid}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined bitwise logic unit; successor to the fixed 32-bit combinational AND in the 32-bit ALU.
- Computes one of eight bitwise operations on two WIDTH-bit operands.
- Result passes through STAGES registered pipeline stages under a valid/ready handshake.
- Sits between the ALU operand mux and the result writeback arbiter; upstream and downstream may both stall.

Parameters:
- WIDTH, 32, operand and result width in bits (legal 1..64).
- STAGES, 2, number of pipeline register stages = latency in cycles (legal 1..4).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  unit accepts beat this cycle.
- in_op  input  3  operation select.
- in1  input  WIDTH  operand A.
- in2  input  WIDTH  operand B.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts result.
- Out  output  WIDTH  result.
- out_op  output  3  op that produced Out.

Behaviour:
- Reset:
  - sampled only on rising clk.
  - Clears all stage valid bits, stage data and stage op registers to 0.
  - Out = 0, out_op = 0, out_valid = 0.
  - in_ready = 0 while reset is high.
  - Reset mid-stream discards every in-flight beat, with no partial output.
- Op encoding:
  - 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR.
  - 110 ANDN (in1 & ~in2), 111 PASS (in1).
- Evaluation: combinational result computed on in1/in2 before stage 1, then carried unchanged through stages 2..STAGES. Full WIDTH, no carry, no truncation.
- Advance:
  - adv = out_ready | ~out_valid, a global pipeline enable.
  - When adv = 1, every stage loads from its predecessor; stage 1 loads {in_valid & in_ready, result, in_op}.
  - When adv = 0, all stages hold.
- Handshake:
  - in_ready = adv & ~reset (combinational).
  - A beat transfers when in_valid & in_ready.
  - Output transfers when out_valid & out_ready.
  - Out and out_op must remain stable while out_valid = 1 and out_ready = 0.
- Latency: a beat accepted at edge N is visible on Out at edge N+STAGES-1 (out_valid high in the cycle after edge N+STAGES-1), assuming no stall.
- Throughput: one beat per cycle while out_ready = 1.
- Bubbles: empty stages are carried, not collapsed. A bubble in the last stage makes adv = 1 regardless of out_ready.
- Simultaneous accept and emit in the same cycle is legal and required for full rate.
- in_op values are all defined; there is no illegal-op state.
- Data registers of invalid stages may hold stale values; only the valid bits matter.

Optional Feature:
- LOGIC_UNIT_FLAGS_EN.
  - Defined: adds outputs out_zero (1) = (result == 0) and out_parity (1) = XOR-reduction of result. Both are computed before stage 1, piped alongside data, reset to 0, and held under stall like Out.
  - Undefined: ports absent; no flag logic or registers.

Decomposition:
- Package logic_unit_pkg:
  - op encoding constants OP_AND..OP_PASS, plus a 3-bit op typedef.
  - STAGES legality limits MIN_STAGES = 1, MAX_STAGES = 4.
- One sub-module, logic_unit_core: purely combinational op evaluation (and flags when enabled). The top instantiates it once and wraps it with the pipeline and handshake.

Test Plan:
- WIDTH=32, STAGES=2, out_ready=1. Send AND in1=11, in2=1, then AND in1=0xFFFFFFFF, in2=123456789.
  - Out=0x00000001, then 0x075BCD15, on consecutive cycles.
  - Each appears 2 cycles after accept.
- Op sweep, in1=0x000000DC, in2=0x00000EED, ops 000..111:
  - AND=0xCC, OR=0xEFD, XOR=0xE31.
  - NAND=0xFFFFFF33, NOR=0xFFFFF102, XNOR=0xFFFFF1CE.
  - ANDN=0x10, PASS=0xDC.
  - out_op matches each op.
- Back-pressure: stream 6 AND beats (0&2, 101&1001, 6&9, 23&23, …), hold out_ready=0 for 4 cycles mid-stream.
  - in_ready drops once the pipe is full.
  - Out held stable during the stall.
  - Results 0, 97, 0, 23 are delivered in order with no loss or duplication.
- Reset mid-operation: assert reset for 1 cycle with 2 beats in flight.
  - Next cycle: out_valid=0, Out=0, in_ready=0 during reset.
  - No pre-reset beat ever emerges.
- Parameter corners: WIDTH=1/STAGES=1 and WIDTH=64/STAGES=4, XOR of all-ones with 0x0.
  - Result is all-ones.
  - Latency equals STAGES.
- LOGIC_UNIT_FLAGS_EN defined:
  - AND 6&9 gives out_zero=1, out_parity=0.
  - OR 6|9=0xF gives out_zero=0, out_parity=0.
  - PASS 0x7 gives out_parity=1.
